// File: rtl/pipe_latch_skid_pkg.sv
// Shared definitions for the inter-stage pipeline latches: reset tag and state encoding.
// The state encoding is reused by every stage latch, so keep EMPTY/ONE/TWO fixed at 0/1/2.
package pipe_latch_skid_pkg;

    // Instruction-set tag that a reset or flushed slot carries; it makes a bubble NOP-shaped.
    localparam logic [31:0] ISET_BASE = 32'h0000_0005;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_latch_skid_slot.sv
// pipe_slot: one registered payload (instr, tag, pc); clear beats load, clear/reset give a NOP-shaped bubble.
// Latency 1 cycle from load to q; no handshake of its own, the owning latch decides when to load.
module pipe_slot
    import pipe_latch_skid_pkg::*;
#(
    parameter int INSTR_W = 12,
    parameter int PC_W    = 12,
    parameter int ISET_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ISET_W-1:0]  iset_d,
    input  logic [PC_W-1:0]    pc_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ISET_W-1:0]  iset_q,
    output logic [PC_W-1:0]    pc_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            iset_q  <= ISET_BASE[ISET_W-1:0];
            pc_q    <= '0;
        end else if (clear) begin
            instr_q <= '0;
            iset_q  <= ISET_BASE[ISET_W-1:0];
            pc_q    <= '0;
        end else if (load) begin
            instr_q <= instr_d;
            iset_q  <= iset_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: rtl/pipe_latch_skid.sv
// Stage latch with valid/ready and optional two-entry skid; 1-cycle accept-to-out_valid, no bypass.
// Backpressure: SKID=1 in_ready comes from registered state only; SKID=0 in_ready = !out_valid | out_ready.
module pipe_latch_skid
    import pipe_latch_skid_pkg::*;
#(
    parameter int INSTR_W = 12,
    parameter int PC_W    = 12,
    parameter int ISET_W  = 4,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ISET_W-1:0]  instr_set_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ISET_W-1:0]  instr_set_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [1:0]         occupancy
);

    pipe_state_t state, state_nxt;

    logic accept;
    logic drain;
    logic head_load;
    logic head_from_skid;
    logic skid_load;

    logic [INSTR_W-1:0] skid_instr;
    logic [ISET_W-1:0]  skid_iset;
    logic [PC_W-1:0]    skid_pc;

    logic [INSTR_W-1:0] head_instr_d;
    logic [ISET_W-1:0]  head_iset_d;
    logic [PC_W-1:0]    head_pc_d;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state_occupancy(state);

    generate
        if (SKID != 0) begin : g_ready_reg
            assign in_ready = (state != ST_TWO);
        end else begin : g_ready_comb
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        // Only reachable with a skid slot; without one, accept implies drain here.
                        if (SKID != 0) begin
                            state_nxt = ST_TWO;
                            skid_load = 1'b1;
                        end else begin
                            head_load = 1'b1;
                        end
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_nxt      = ST_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        head_instr_d = instr_in;
        head_iset_d  = instr_set_in;
        head_pc_d    = pc_in;
        if (head_from_skid) begin
            head_instr_d = skid_instr;
            head_iset_d  = skid_iset;
            head_pc_d    = skid_pc;
        end
    end

    pipe_slot #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .ISET_W  (ISET_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (head_load),
        .clear   (flush),
        .instr_d (head_instr_d),
        .iset_d  (head_iset_d),
        .pc_d    (head_pc_d),
        .instr_q (instr_out),
        .iset_q  (instr_set_out),
        .pc_q    (pc_out)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .INSTR_W (INSTR_W),
                .PC_W    (PC_W),
                .ISET_W  (ISET_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (flush),
                .instr_d (instr_in),
                .iset_d  (instr_set_in),
                .pc_d    (pc_in),
                .instr_q (skid_instr),
                .iset_q  (skid_iset),
                .pc_q    (skid_pc)
            );
        end else begin : g_no_skid
            assign skid_instr = '0;
            assign skid_iset  = '0;
            assign skid_pc    = '0;
        end
    endgenerate

    a_state_legal: assert property (@(posedge clk) disable iff (rst) state != 2'd3);

    // A stalled head must not move or disappear unless flushed.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable({instr_out, instr_set_out, pc_out})));

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: one instance per SKID value, directed vectors plus a short random phase,
// a queue scoreboard filled by the driver and drained by a per-instance monitor.
module tb_pipe_latch_skid;

    typedef struct packed {
        logic [11:0] instr;
        logic [3:0]  iset;
        logic [11:0] pc;
    } pay_t;

    localparam logic [3:0] RST_ISET = 4'h5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [11:0] instr_in  [2];
    logic [3:0]  iset_in   [2];
    logic [11:0] pc_in     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [11:0] instr_out [2];
    logic [3:0]  iset_out  [2];
    logic [11:0] pc_out    [2];
    logic [1:0]  occ       [2];

    int compared   = 0;
    int mismatched = 0;

    pay_t q0[$];
    pay_t q1[$];

    always #5 clk = ~clk;

    pipe_latch_skid #(.INSTR_W(12), .PC_W(12), .ISET_W(4), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .instr_in(instr_in[0]), .instr_set_in(iset_in[0]), .pc_in(pc_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .instr_out(instr_out[0]), .instr_set_out(iset_out[0]), .pc_out(pc_out[0]),
        .occupancy(occ[0])
    );

    pipe_latch_skid #(.INSTR_W(12), .PC_W(12), .ISET_W(4), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .instr_in(instr_in[1]), .instr_set_in(iset_in[1]), .pc_in(pc_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .instr_out(instr_out[1]), .instr_set_out(iset_out[1]), .pc_out(pc_out[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int m);
        return (m != 0) ? q1.size() : q0.size();
    endfunction

    function automatic pay_t qfront(input int m);
        return (m != 0) ? q1[0] : q0[0];
    endfunction

    task automatic qpush(input int m, input pay_t p);
        if (m != 0) q1.push_back(p); else q0.push_back(p);
    endtask

    task automatic qpop(input int m);
        pay_t d;
        if (m != 0) d = q1.pop_front(); else d = q0.pop_front();
    endtask

    task automatic qclr(input int m);
        if (m != 0) q1.delete(); else q0.delete();
    endtask

    // One cycle of upstream/downstream stimulus; handshakes are judged 1 time unit before the edge.
    task automatic step(input int m, input logic v, input logic [11:0] ins, input logic [3:0] ts,
                        input logic [11:0] pc, input logic ordy, input logic fl, output logic acc);
        pay_t p;
        @(negedge clk);
        in_valid[m]  = v;
        instr_in[m]  = ins;
        iset_in[m]   = ts;
        pc_in[m]     = pc;
        out_ready[m] = ordy;
        flush[m]     = fl;
        #4;
        acc = v & in_ready[m];
        p   = '{instr: ins, iset: ts, pc: pc};
        if (fl) qclr(m);
        else if (acc) qpush(m, p);
    endtask

    task automatic idle(input int m, input logic ordy, output logic acc);
        step(m, 1'b0, 12'h000, 4'h0, 12'h000, ordy, 1'b0, acc);
    endtask

    task automatic monitor(input int m);
        int   sz;
        pay_t f;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                sz = qsize(m);
                chk($sformatf("occ_m%0d", m), {30'd0, occ[m]}, sz);
                chk($sformatf("valid_m%0d", m), {31'd0, out_valid[m]}, {31'd0, sz != 0});
                if (sz != 0) begin
                    f = qfront(m);
                    chk($sformatf("head_m%0d", m), {4'd0, instr_out[m], iset_out[m], pc_out[m]}, {4'd0, f});
                    if (out_valid[m] && out_ready[m]) qpop(m);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic rand_run(input int m, input int n);
        logic        acc, pend, v, ordy, fl;
        logic [11:0] ins;
        int          cnt;
        pend = 1'b0;
        cnt  = 0;
        ins  = 12'h000;
        for (int i = 0; i < n; i++) begin
            v = pend ? 1'b1 : ($urandom_range(0, 99) < 60);
            if (!pend) begin
                cnt++;
                ins = 12'h800 | (12'(m) << 10) | 12'(cnt & 10'h3FF);
            end
            ordy = ($urandom_range(0, 99) < 65);
            fl   = ($urandom_range(0, 99) < 5);
            step(m, v, ins, ins[3:0], ~ins, ordy, fl, acc);
            pend = v && !acc;
        end
        for (int i = 0; i < 4; i++) idle(m, 1'b1, acc);
        chk($sformatf("rand_empty_m%0d", m), qsize(m), 0);
        chk($sformatf("rand_occ_m%0d", m), {30'd0, occ[m]}, 32'd0);
    endtask

    task automatic zero_inputs();
        for (int m = 0; m < 2; m++) begin
            flush[m] = 1'b0; in_valid[m] = 1'b0; out_ready[m] = 1'b0;
            instr_in[m] = '0; iset_in[m] = '0; pc_in[m] = '0;
        end
    endtask

    initial begin : main
        logic acc;
        rst = 1'b1;
        zero_inputs();
        #3;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_valid_m%0d", m), {31'd0, out_valid[m]}, 32'd0);
            chk($sformatf("rst_iset_m%0d", m), {28'd0, iset_out[m]}, {28'd0, RST_ISET});
            chk($sformatf("rst_ready_m%0d", m), {31'd0, in_ready[m]}, 32'd1);
            chk($sformatf("rst_occ_m%0d", m), {30'd0, occ[m]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Streaming through the skid latch: no bypass, then one per cycle.
        for (int i = 0; i < 10; i++) begin
            step(1, 1'b1, 12'h101 + 12'(i), 4'h3, 12'(i), 1'b1, 1'b0, acc);
            chk("stream_acc", {31'd0, acc}, 32'd1);
            chk("stream_lat", {31'd0, out_valid[1]}, {31'd0, i != 0});
        end
        idle(1, 1'b1, acc);
        chk("stream_last", {20'd0, instr_out[1]}, 32'h10A);
        idle(1, 1'b1, acc);
        chk("stream_done", {31'd0, out_valid[1]}, 32'd0);

        // Backpressure: two accepted, third held off until the head moves.
        step(1, 1'b1, 12'hA01, 4'h2, 12'h0A1, 1'b0, 1'b0, acc);
        chk("bp_acc1", {31'd0, acc}, 32'd1);
        step(1, 1'b1, 12'hA02, 4'h2, 12'h0A2, 1'b0, 1'b0, acc);
        chk("bp_acc2", {31'd0, acc}, 32'd1);
        step(1, 1'b1, 12'hA03, 4'h2, 12'h0A3, 1'b0, 1'b0, acc);
        chk("bp_acc3", {31'd0, acc}, 32'd0);
        chk("bp_occ2", {30'd0, occ[1]}, 32'd2);
        chk("bp_head", {20'd0, instr_out[1]}, 32'hA01);
        step(1, 1'b1, 12'hA03, 4'h2, 12'h0A3, 1'b1, 1'b0, acc);
        chk("bp_rel_rdy", {31'd0, acc}, 32'd0);
        step(1, 1'b1, 12'hA03, 4'h2, 12'h0A3, 1'b1, 1'b0, acc);
        chk("bp_a03_acc", {31'd0, acc}, 32'd1);
        chk("bp_head2", {20'd0, instr_out[1]}, 32'hA02);
        idle(1, 1'b1, acc);
        chk("bp_head3", {20'd0, instr_out[1]}, 32'hA03);
        idle(1, 1'b1, acc);
        chk("bp_empty", {30'd0, occ[1]}, 32'd0);

        // Flush with two held and 0xB07 offered.
        step(1, 1'b1, 12'hB05, 4'h7, 12'h0B5, 1'b0, 1'b0, acc);
        step(1, 1'b1, 12'hB06, 4'h7, 12'h0B6, 1'b0, 1'b0, acc);
        step(1, 1'b1, 12'hB07, 4'h7, 12'h0B7, 1'b0, 1'b1, acc);
        chk("fl_occ_before", {30'd0, occ[1]}, 32'd2);
        idle(1, 1'b0, acc);
        chk("fl_valid", {31'd0, out_valid[1]}, 32'd0);
        chk("fl_occ", {30'd0, occ[1]}, 32'd0);
        chk("fl_instr", {20'd0, instr_out[1]}, 32'd0);
        chk("fl_iset", {28'd0, iset_out[1]}, {28'd0, RST_ISET});
        chk("fl_pc", {20'd0, pc_out[1]}, 32'd0);
        chk("fl_ready", {31'd0, in_ready[1]}, 32'd1);
        // Flush from one entry while an accept handshakes: the payload is lost.
        step(1, 1'b1, 12'hB08, 4'h7, 12'h0B8, 1'b0, 1'b0, acc);
        step(1, 1'b1, 12'hB09, 4'h7, 12'h0B9, 1'b0, 1'b1, acc);
        chk("fl1_rdy_ungated", {31'd0, acc}, 32'd1);
        idle(1, 1'b1, acc);
        chk("fl1_valid", {31'd0, out_valid[1]}, 32'd0);
        idle(1, 1'b1, acc);
        chk("fl1_still_empty", {31'd0, out_valid[1]}, 32'd0);

        // Asynchronous reset in the middle of a cycle with two entries held.
        step(1, 1'b1, 12'hD01, 4'h1, 12'h0D1, 1'b0, 1'b0, acc);
        step(1, 1'b1, 12'hD02, 4'h1, 12'h0D2, 1'b0, 1'b0, acc);
        idle(1, 1'b0, acc);
        chk("mrst_occ_before", {30'd0, occ[1]}, 32'd2);
        @(negedge clk);
        zero_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, out_valid[1]}, 32'd0);
        chk("mrst_iset", {28'd0, iset_out[1]}, {28'd0, RST_ISET});
        chk("mrst_occ", {30'd0, occ[1]}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready[1]}, 32'd1);
        qclr(0);
        qclr(1);
        @(negedge clk);
        rst = 1'b0;

        // SKID=0: ready follows out_ready combinationally, head replaced on accept+drain.
        step(0, 1'b1, 12'hC01, 4'h4, 12'h0C1, 1'b0, 1'b0, acc);
        chk("s0_acc1", {31'd0, acc}, 32'd1);
        step(0, 1'b1, 12'hC02, 4'h4, 12'h0C2, 1'b0, 1'b0, acc);
        chk("s0_stall_rdy", {31'd0, in_ready[0]}, 32'd0);
        step(0, 1'b1, 12'hC02, 4'h4, 12'h0C2, 1'b1, 1'b0, acc);
        chk("s0_comb_rdy", {31'd0, in_ready[0]}, 32'd1);
        chk("s0_head1", {20'd0, instr_out[0]}, 32'hC01);
        idle(0, 1'b0, acc);
        chk("s0_head2", {20'd0, instr_out[0]}, 32'hC02);
        chk("s0_occ1", {30'd0, occ[0]}, 32'd1);
        idle(0, 1'b1, acc);
        idle(0, 1'b1, acc);
        chk("s0_empty", {30'd0, occ[0]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1, 12'h301 + 12'(i), 4'h6, 12'h030 + 12'(i), 1'b1, 1'b0, acc);
            chk("s0_stream_acc", {31'd0, acc}, 32'd1);
            chk("s0_stream_lat", {31'd0, out_valid[0]}, {31'd0, i != 0});
        end
        idle(0, 1'b1, acc);
        idle(0, 1'b1, acc);

        fork
            rand_run(0, 300);
            rand_run(1, 300);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
